// File: rtl/wb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : wb_register_file
// Purpose  : MIPS write-back stage plus 32 x DATA_W architectural register
//            file. Selects the write-back value from the MEM/WB outputs,
//            commits it on posedge Clk, serves two ID read ports with
//            same-cycle write-through bypass, exports the committed write for
//            forwarding and counts committed writes for debug.
// Ports    : Clk, Rst (sync, active-high)
//            MemReg_in, RegWrite_in, ReadData_in, ALUResult_in,
//            PC2ndAdder_in, RtRd_in          - MEM/WB pipeline register
//            ReadReg1/2 -> ReadData1/2       - ID read ports (bypassed)
//            WBData_out, WBReg_out, WBEn_out - committed write to forwarding
//            DbgReg -> DbgData               - debug read (array only)
//            WriteCount                      - committed-write counter
// Revision : 1.0 - initial release
// ============================================================================
module wb_register_file #(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [1:0]         MemReg_in,
    input  logic               RegWrite_in,
    input  logic [DATA_W-1:0]  ReadData_in,
    input  logic [DATA_W-1:0]  ALUResult_in,
    input  logic [DATA_W-1:0]  PC2ndAdder_in,
    input  logic [31:0]        RtRd_in,
    input  logic [4:0]         ReadReg1,
    input  logic [4:0]         ReadReg2,
    output logic [DATA_W-1:0]  ReadData1,
    output logic [DATA_W-1:0]  ReadData2,
    output logic [DATA_W-1:0]  WBData_out,
    output logic [4:0]         WBReg_out,
    output logic               WBEn_out,
    input  logic [4:0]         DbgReg,
    output logic [DATA_W-1:0]  DbgData,
    output logic [COUNT_W-1:0] WriteCount
);

    localparam int c_NUM_REGS = 32;

    logic [DATA_W-1:0]  w_wb_data;
    logic [4:0]         w_wb_reg;
    logic               w_wb_en;
    logic [DATA_W-1:0]  w_rf [0:c_NUM_REGS-1];
    logic [COUNT_W-1:0] r_count;

    // Only the low five bits of the destination field address the file.
    logic               w_unused_rtrd_hi;
    assign w_unused_rtrd_hi = ^RtRd_in[31:5];

    // Write-back source select; the reserved encoding falls back to ALU.
    always_comb begin
        w_wb_data = ALUResult_in;
        case (MemReg_in)
            2'b01:   w_wb_data = ReadData_in;
            2'b10:   w_wb_data = PC2ndAdder_in;
            default: w_wb_data = ALUResult_in;
        endcase
    end

    assign w_wb_reg = RtRd_in[4:0];
    // Writes to $0 are neither committed nor counted, and reset drops writes.
    assign w_wb_en  = RegWrite_in & (w_wb_reg != 5'd0) & ~Rst;

    assign WBData_out = w_wb_data;
    assign WBReg_out  = w_wb_reg;
    assign WBEn_out   = w_wb_en;

    // Register 0 is a constant; the other 31 entries are real storage.
    assign w_rf[0] = '0;

    generate
        for (genvar i = 1; i < c_NUM_REGS; i++) begin : g_reg
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    r_q <= '0;
                end else if (w_wb_en && (w_wb_reg == 5'(i))) begin
                    r_q <= w_wb_data;
                end
            end
            assign w_rf[i] = r_q;
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_count <= '0;
        end else if (w_wb_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign WriteCount = r_count;

    // Read ports: the bypass makes a write visible in the cycle it is
    // presented, replacing the classic negedge-write register file.
    always_comb begin
        ReadData1 = w_rf[ReadReg1];
        if (Rst || (ReadReg1 == 5'd0)) begin
            ReadData1 = '0;
        end else if (w_wb_en && (ReadReg1 == w_wb_reg)) begin
            ReadData1 = w_wb_data;
        end
    end

    always_comb begin
        ReadData2 = w_rf[ReadReg2];
        if (Rst || (ReadReg2 == 5'd0)) begin
            ReadData2 = '0;
        end else if (w_wb_en && (ReadReg2 == w_wb_reg)) begin
            ReadData2 = w_wb_data;
        end
    end

    // Debug port sees the array only: no bypass, no reset gating.
    assign DbgData = w_rf[DbgReg];

endmodule
`default_nettype wire

// File: doc/wb_register_file.md
# wb_register_file

Write-back stage and architectural register file for the 5-stage MIPS datapath. Consumes the MEM/WB pipeline register outputs each cycle and selects the write-back value by MemReg. Commits that value into a 32 x 32-bit register file and serves the two ID-stage read ports with same-cycle write-through bypass. Also exports the committed write for the forwarding unit and keeps a committed-write counter for debug.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- COUNT_W, 32, width of the committed-write counter

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  reset, synchronous, active-high
- MemReg_in  in  2  write-back source select from MEM/WB
- RegWrite_in  in  1  write enable from MEM/WB
- ReadData_in  in  DATA_W  data-memory load value
- ALUResult_in  in  DATA_W  ALU result
- PC2ndAdder_in  in  DATA_W  link address for jal
- RtRd_in  in  32  destination register number; only bits [4:0] used
- ReadReg1  in  5  ID read port 1 address (rs)
- ReadReg2  in  5  ID read port 2 address (rt)
- ReadData1  out  DATA_W  port 1 data, combinational
- ReadData2  out  DATA_W  port 2 data, combinational
- WBData_out  out  DATA_W  selected write-back value, combinational
- WBReg_out  out  5  RtRd_in[4:0], combinational
- WBEn_out  out  1  effective write this cycle, combinational
- DbgReg  in  5  debug read address
- DbgData  out  DATA_W  debug read data, no bypass
- WriteCount  out  COUNT_W  number of committed writes, registered

## Operation
- Source select: MemReg 00 -> ALUResult_in; 01 -> ReadData_in; 10 -> PC2ndAdder_in; 11 -> ALUResult_in (reserved, treated as 00).
- Effective write: WBEn_out = RegWrite_in & (RtRd_in[4:0] != 0) & ~Rst.
- On posedge Clk with WBEn_out=1: regs[RtRd_in[4:0]] <= WBData_out and WriteCount <= WriteCount + 1.
- Register 0 is hardwired to 0. Writes to it are discarded and not counted. Reads of address 0 return 0 on every port.
- RtRd_in[31:5] is ignored and does not affect address decode.
- Read port N: if Rst=1, output 0. Else if ReadRegN == 0, output 0. Else if WBEn_out=1 and ReadRegN == WBReg_out, output WBData_out (bypass). Otherwise output regs[ReadRegN].
- Both read ports may bypass the same write simultaneously.
- DbgData = regs[DbgReg] (0 for address 0). It has no bypass and is not gated by Rst.
- WriteCount wraps from 2^COUNT_W-1 to 0 with no flag.

## Timing
- Reset: on posedge Clk with Rst=1, all 31 writable registers clear to 0 and WriteCount clears to 0.
- While Rst=1: ReadData1=0, ReadData2=0, WBEn_out=0. WBData_out and WBReg_out still follow their inputs.
- A write presented with Rst=1 is dropped. Reset wins over any simultaneous write.
- Write latency: value is visible through bypass in the same cycle it is presented. It is visible from the array (and on DbgData) from the cycle after the posedge.
- Bypass replaces the negedge-write scheme. The register file is posedge-only; no negedge logic anywhere.
- Back-to-back writes to the same register: the later write wins. Each write is counted separately.
- No stall or handshake. Every cycle's MEM/WB contents are consumed exactly once.

## Test plan
- Reset: preload several registers, assert Rst for 1 cycle -> all DbgData reads 0, WriteCount=0, ReadData1/2=0 during Rst.
- Basic write/read: RegWrite=1, MemReg=01, ReadData_in=0xDEADBEEF, RtRd=8; next cycle ReadReg1=8 with RegWrite=0 -> ReadData1=0xDEADBEEF, WriteCount=1.
- Bypass: RegWrite=1, MemReg=00, ALUResult=0x12345678, RtRd=9, ReadReg1=ReadReg2=9 in the same cycle -> both outputs 0x12345678 before the edge; DbgReg=9 shows old value until after the edge.
- $0 protection: RegWrite=1, RtRd=0x00000020 (bits[4:0]=0), ALUResult=0xFFFFFFFF -> WBEn_out=0, register 0 reads 0, WriteCount unchanged.
- Link and select: MemReg=10, PC2ndAdder=0x00400008, RtRd=31 -> reg 31 = 0x00400008. MemReg=11 with ALUResult=0x5 to reg 2 -> reg 2 = 5.
- Reset mid-stream and wrap: with COUNT_W=4, perform 16 writes -> WriteCount=0. Assert Rst in the same cycle as a write to reg 4 -> reg 4 stays 0 and WriteCount stays 0.
